// File: rtl/micro_tile_sequencer_if.sv
// Request handshake between a tile requester and micro_tile_sequencer.
interface micro_tile_sequencer_if;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;

  modport master (output req_valid, output req_sel, input req_ready);
  modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/micro_tile_sequencer.sv
// Hand-off sequencer for the four-slot micro-tile container (manual or round-robin auto).
// Optional tile masking is enabled by defining MICRO_TILE_SEQ_MASK_EN.
module micro_tile_sequencer #(
  parameter int RST_CYCLES = 4,
  parameter int DWELL_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_i,
  input  logic [DWELL_W-1:0]   dwell_i,
  micro_tile_sequencer_if.slave req_if,
`ifdef MICRO_TILE_SEQ_MASK_EN
  input  logic [3:0]           tile_mask_i,
  output logic                 req_err_o,
`endif
  output logic [1:0]           sel_o,
  output logic [3:0]           tile_clk_en_o,
  output logic [3:0]           tile_rst_n_o,
  output logic                 busy_o,
  output logic                 switch_done_o
);
  // state  | meaning
  // WAKE   | incoming tile clocked but held in reset
  // ACTIVE | selected tile running
  // DRAIN  | outgoing tile clocks its reset in
  // GATE   | all clocks off while the select moves
  typedef enum logic [1:0] {WAKE, ACTIVE, DRAIN, GATE} state_e;

  localparam int WCW = $clog2(RST_CYCLES + 1);

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d, target_q, target_d;
  logic [WCW-1:0]     wake_q, wake_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         clk_en_q, clk_en_d, rst_n_q, rst_n_d;
  logic               busy_q, busy_d, ready_q, ready_d, done_q, done_d;
  logic               accept, err_d;
  logic [1:0]         nxt;
  logic               nxt_ok;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign accept = req_if.req_valid && ready_q;

`ifdef MICRO_TILE_SEQ_MASK_EN
  logic err_q;
  // Nearest unmasked tile after sel, wrapping; the current tile is never a candidate.
  always_comb begin
    nxt    = sel_q + 2'd1;
    nxt_ok = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      if (!tile_mask_i[sel_q + 2'(k)]) begin
        nxt    = sel_q + 2'(k);
        nxt_ok = 1'b1;
      end
    end
  end
  assign req_err_o = err_q;
`else
  assign nxt    = sel_q + 2'd1;
  assign nxt_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    wake_d   = wake_q;
    dwell_d  = '0;
    err_d    = 1'b0;
    case (state_q)
      WAKE: begin
        if (wake_q == WCW'(1)) state_d = ACTIVE;
        else                   wake_d  = wake_q - 1'b1;
      end
      ACTIVE: begin
        if (accept) begin
`ifdef MICRO_TILE_SEQ_MASK_EN
          if (tile_mask_i[req_if.req_sel]) begin
            err_d = 1'b1;
          end else
`endif
          if (req_if.req_sel != sel_q) begin
            target_d = req_if.req_sel;
            state_d  = DRAIN;
          end
        end else if (mode_i && dwell_i != '0) begin
          if (dwell_q == dwell_i - 1'b1) begin
            if (nxt_ok) begin
              target_d = nxt;
              state_d  = DRAIN;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      DRAIN: state_d = GATE;
      GATE: begin
        sel_d   = target_q;
        wake_d  = WCW'(RST_CYCLES);
        state_d = WAKE;
      end
      default: state_d = WAKE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    clk_en_d = (state_d == GATE)   ? 4'b0000 : onehot(sel_d);
    rst_n_d  = (state_d == ACTIVE) ? onehot(sel_d) : 4'b0000;
    busy_d   = (state_d != ACTIVE);
    ready_d  = (state_d == ACTIVE) && !mode_i;
    done_d   = (state_d == ACTIVE) && (state_q != ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAKE;
      sel_q    <= 2'd0;
      target_q <= 2'd0;
      wake_q   <= WCW'(RST_CYCLES);
      dwell_q  <= '0;
      clk_en_q <= 4'b0001;
      rst_n_q  <= 4'b0000;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      wake_q   <= wake_d;
      dwell_q  <= dwell_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

`ifdef MICRO_TILE_SEQ_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  assign req_if.req_ready = ready_q;
  assign sel_o            = sel_q;
  assign tile_clk_en_o    = clk_en_q;
  assign tile_rst_n_o     = rst_n_q;
  assign busy_o           = busy_q;
  assign switch_done_o    = done_q;
endmodule
